// File: rtl/fifo_stream_pkg.sv
// Shared types and default sizes for the sync FIFO and its read-side streamer.
package fifo_stream_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int BUF_DEPTH  = 4;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } strm_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Circular skid buffer behind the FIFO read port; the head entry drives the master port.
module stream_skid_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   occ,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            // Flush empties the buffer by snapping the read side onto the write side.
            if (flush) begin
                occ    <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + (PTR_W + 1)'(1);
                    2'b01:   occ <= occ - (PTR_W + 1)'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    assign m_valid = (occ != '0);
    assign m_data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO drain stage: read issue, enable/drain/flush FSM and a valid/ready master port.
// Define STREAMER_STATS_EN to add beat_cnt and the sticky err_underflow flag.
//
// Handshake: a word transfers on every rising edge where m_valid & m_ready;
// m_data is held stable while m_valid & !m_ready, and m_valid never depends on m_ready.
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = fifo_stream_pkg::FIFO_WIDTH,
    parameter int BUF_DEPTH  = fifo_stream_pkg::BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  idle,
`ifdef STREAMER_STATS_EN
    output logic [15:0]           beat_cnt,
    output logic                  err_underflow,
`endif
    output logic [1:0]            state
);

    import fifo_stream_pkg::*;

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

    strm_state_e      state_q;
    strm_state_e      state_d;
    logic             inflight;
    logic             push;
    logic             pop;
    logic             drain_done;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   level;

    assign push  = inflight & ~flush;
    assign pop   = m_valid & m_ready;
    assign level = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

    // Only registered state and fifo_empty feed the read strobe, never m_ready.
    assign fifo_rd_en = (state_q == RUN) & ~fifo_empty & ~flush
                      & (level < (OCC_W + 1)'(BUF_DEPTH));

    // The last word leaves this cycle, so the FSM can retire on the same edge.
    assign drain_done = ~inflight & ((occ == '0) | ((occ == OCC_W'(1)) & pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DISABLED;
            inflight <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= fifo_rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = en ? RUN : DISABLED;
        end else begin
            case (state_q)
                DISABLED: if (en) state_d = RUN;
                RUN:      if (!en) state_d = DRAIN;
                DRAIN: begin
                    if (en)              state_d = RUN;
                    else if (drain_done) state_d = DISABLED;
                end
                default:  state_d = DISABLED;
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .flush     (flush),
        .occ       (occ),
        .m_valid   (m_valid),
        .m_data    (m_data)
    );

    assign idle  = (state_q == DISABLED) & (occ == '0);
    assign state = state_q;

`ifdef STREAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop)            beat_cnt      <= beat_cnt + 16'd1;
            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end
`else
    logic unused_underflow;
    assign unused_underflow = fifo_underflow;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a FIFO model and an output-order scoreboard.
module tb_fifo_rd_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out  = 16'h0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        idle;
    logic [1:0]  state;
`ifdef STREAMER_STATS_EN
    logic [15:0] beat_cnt;
    logic        err_underflow;
`endif

    fifo_rd_streamer #(.FIFO_WIDTH(16), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .idle           (idle),
`ifdef STREAMER_STATS_EN
        .beat_cnt       (beat_cnt),
        .err_underflow  (err_underflow),
`endif
        .state          (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO model (read data one cycle after rd_en) ----------------
    logic [15:0] fmem [0:255];
    int          fwr = 0;
    int          frd = 0;

    assign fifo_empty = (fwr == frd);

    always @(posedge clk) begin
        fifo_underflow <= fifo_rd_en && (fwr == frd);
        if (fifo_rd_en) begin
            fifo_data_out <= fmem[frd];
            frd           <= frd + 1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [15:0] data;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt, acc_cnt, total_acc;
    int          first_rd, last_rd, first_v, first_acc, last_acc;
    logic        underflow_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A word read in cycle t must be at the head of the output port from cycle t+2,
    // words come out in read order, and a flush discards everything not yet accepted.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (rst) begin
            exp_q.delete();
            total_acc = 0;
        end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
            if (m_valid && exp_v) chk("m_data", {16'd0, m_data}, {16'd0, exp_q[0].data});
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                acc_cnt++;
                total_acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (fifo_rd_en) begin
                chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                e.data  = fmem[frd];
                e.t     = cyc;
                exp_q.push_back(e);
            end
            if (flush) exp_q.delete();
            if (fifo_underflow) underflow_seen = 1'b1;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [15:0] d);
        fmem[fwr] = d;
        fwr = fwr + 1;
    endtask

    task automatic fifo_clear();
        fwr = frd;
    endtask

    task automatic clear_mon();
        rd_cnt = 0; acc_cnt = 0; got_q.delete();
        first_rd = -1; last_rd = -1; first_v = -1; first_acc = -1; last_acc = -1;
        underflow_seen = 1'b0;
    endtask

    function automatic logic [15:0] got(input int i);
        return (i < got_q.size()) ? got_q[i] : 16'hDEAD;
    endfunction

    task automatic wait_acc(input string name, input int n, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            sample();
            ok = (acc_cnt >= n);
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_rd(input string name, input int n, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            sample();
            ok = (rd_cnt >= n);
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic end_test(input string name);
        logic ok = 1'b0;
        en = 1'b0; m_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            sample();
            ok = idle;
        end
        chk(name, {31'd0, ok}, 32'd1);
        tick();
        fifo_clear();
        clear_mon();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; m_ready = 1'b1;
        clear_mon();
        fifo_write(16'h0001); fifo_write(16'h0002); fifo_write(16'h0003);

        // 1: reset with en=1 and a non-empty FIFO
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
            chk("rst_m_valid", {31'd0, m_valid},    32'd0);
            chk("rst_m_data",  {16'd0, m_data},     32'd0);
            chk("rst_idle",    {31'd0, idle},       32'd1);
        end
        tick();
        rst = 1'b0; en = 1'b0;
        fifo_clear();
        tick();
        clear_mon();

        // 2: full-rate streaming of 0x0001..0x0008
        for (int i = 1; i <= 8; i++) fifo_write(16'(i));
        en = 1'b1; m_ready = 1'b1;
        wait_acc("stream_timeout", 8, 40);
        chk("stream_rd_cnt",    rd_cnt,              32'd8);
        chk("stream_rd_span",   last_rd - first_rd,  32'd7);
        chk("stream_latency",   first_v - first_rd,  32'd2);
        chk("stream_b2b",       last_acc - first_acc, 32'd7);
        for (int i = 0; i < 8; i++) chk("stream_word", {16'd0, got(i)}, 32'(i + 1));
        end_test("stream_idle");

        // 3: backpressure stops reads at buffer capacity
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_write(16'(i));
        en = 1'b1;
        repeat (10) sample();
        chk("bp_rd_cnt",  rd_cnt,                32'd4);
        chk("bp_rd_en",   {31'd0, fifo_rd_en},  32'd0);
        chk("bp_m_valid", {31'd0, m_valid},     32'd1);
        chk("bp_m_data",  {16'd0, m_data},      32'h0001);
        tick();
        m_ready = 1'b1;
        wait_acc("bp_timeout", 8, 40);
        repeat (4) sample();
        chk("bp_rd_total",  rd_cnt,  32'd8);
        chk("bp_acc_total", acc_cnt, 32'd8);
        for (int i = 0; i < 8; i++) chk("bp_word", {16'd0, got(i)}, 32'(i + 1));
        end_test("bp_idle");

        // 4: single word, FIFO goes empty
        m_ready = 1'b1;
        fifo_write(16'h00AA);
        en = 1'b1;
        repeat (10) sample();
        chk("empty_rd_cnt",   rd_cnt,                   32'd1);
        chk("empty_acc_cnt",  acc_cnt,                  32'd1);
        chk("empty_word",     {16'd0, got(0)},          32'h00AA);
        chk("empty_m_valid",  {31'd0, m_valid},         32'd0);
        chk("empty_underflow", {31'd0, underflow_seen}, 32'd0);
        end_test("empty_idle");

        // 5: drain with occ=3, inflight=1
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_write(16'h0051 + 16'(i));
        en = 1'b1;
        wait_rd("drain_start", 1, 20);
        repeat (4) tick();
        en = 1'b0; m_ready = 1'b1;
        chk("drain_rd_at_stop", rd_cnt, 32'd4);
        wait_acc("drain_timeout", 4, 20);
        sample();
        chk("drain_idle",   {31'd0, idle},  32'd1);
        chk("drain_state",  {30'd0, state}, 32'd0);
        repeat (3) sample();
        chk("drain_rd_cnt", rd_cnt,  32'd4);
        chk("drain_acc",    acc_cnt, 32'd4);
        for (int i = 0; i < 4; i++) chk("drain_word", {16'd0, got(i)}, 32'h0051 + 32'(i));
        end_test("drain_end");

        // 6: flush with occ=2, inflight=1; the pop in the flush cycle still counts
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(16'h0061 + 16'(i));
        en = 1'b1;
        wait_rd("flush_start", 1, 20);
        repeat (3) tick();
        flush = 1'b1; m_ready = 1'b1;
        chk("flush_rd_before", rd_cnt, 32'd3);
        tick();
        flush = 1'b0;
        sample();
        chk("flush_m_valid", {31'd0, m_valid},    32'd0);
        chk("flush_resume",  {31'd0, fifo_rd_en}, 32'd1);
        chk("flush_acc1",    acc_cnt,             32'd1);
        wait_acc("flush_timeout", 6, 40);
        repeat (4) sample();
        chk("flush_acc_total", acc_cnt, 32'd6);
        chk("flush_rd_total",  rd_cnt,  32'd8);
        chk("flush_word0", {16'd0, got(0)}, 32'h0061);
        for (int i = 1; i < 6; i++) chk("flush_word", {16'd0, got(i)}, 32'h0063 + 32'(i));
`ifdef STREAMER_STATS_EN
        chk("stats_beat_cnt", {16'd0, beat_cnt},   32'(total_acc));
        chk("stats_beat_lit", {16'd0, beat_cnt},   32'd27);
        chk("stats_err_uf",   {31'd0, err_underflow}, 32'd0);
`endif
        end_test("flush_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
